// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a nibble-load / serial-shift / bit-serial CRC-16 datapath.
// Serializes payload nibbles MSB-first, then shifts the captured LFSR result out behind them.
`timescale 1ns/1ps
module crc_frame_ctrl #(
  parameter int MAX_NIBBLES = 256,
  parameter int CRC_W       = 16
) (
  input  logic             Clk,
  input  logic             R,
  input  logic [3:0]       din,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
  input  logic [CRC_W-1:0] crc_in,
  input  logic             tx_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_phase,
  output logic             lfsr_clr,
  output logic             lfsr_en,
  output logic             sl,
  output logic             busy,
  output logic             done,
  output logic             ovf_err
);

  localparam int NW = $clog2(MAX_NIBBLES) + 1;
  localparam int CW = $clog2(CRC_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    SHIFT,
    CRC_CAP,
    CRC_SHIFT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       dreg, dreg_nxt;
  logic [CRC_W-1:0] creg, creg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [NW-1:0]    nib_cnt, nib_cnt_nxt;
  logic [NW-1:0]    nib_inc;
  logic             last_flag, last_nxt;
  logic             ovf, ovf_nxt;
  logic             hit_max;

  assign nib_inc = nib_cnt + NW'(1);
  assign hit_max = (nib_inc == NW'(MAX_NIBBLES));
  assign ovf_err = ovf;
  assign busy    = (state != IDLE);

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state     <= IDLE;
      dreg      <= '0;
      creg      <= '0;
      cnt       <= '0;
      nib_cnt   <= '0;
      last_flag <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      dreg      <= dreg_nxt;
      creg      <= creg_nxt;
      cnt       <= cnt_nxt;
      nib_cnt   <= nib_cnt_nxt;
      last_flag <= last_nxt;
      ovf       <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dreg_nxt    = dreg;
    creg_nxt    = creg;
    cnt_nxt     = cnt;
    nib_cnt_nxt = nib_cnt;
    last_nxt    = last_flag;
    ovf_nxt     = ovf;
    din_ready   = 1'b0;
    ser_bit     = 1'b0;
    ser_valid   = 1'b0;
    ser_phase   = 1'b0;
    lfsr_clr    = 1'b0;
    lfsr_en     = 1'b0;
    sl          = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        // The waiting nibble is left on the bus; LOAD consumes it after the clear.
        if (din_valid) state_nxt = CLR;
      end

      CLR: begin
        lfsr_clr    = 1'b1;
        nib_cnt_nxt = '0;
        last_nxt    = 1'b0;
        ovf_nxt     = 1'b0;
        state_nxt   = LOAD;
      end

      LOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          dreg_nxt    = din;
          cnt_nxt     = '0;
          nib_cnt_nxt = nib_inc;
          last_nxt    = din_last | hit_max;
          // Overflow only when the length cap, not the sender, closed the frame.
          if (hit_max && !din_last) ovf_nxt = 1'b1;
          state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = dreg[3];
        lfsr_en   = tx_ready;
        if (tx_ready) begin
          dreg_nxt = {dreg[2:0], 1'b0};
          cnt_nxt  = cnt + CW'(1);
          if (cnt == CW'(3)) state_nxt = last_flag ? CRC_CAP : LOAD;
        end
      end

      CRC_CAP: begin
        // One idle cycle lets the LFSR absorb the final data bit before capture.
        sl        = 1'b1;
        creg_nxt  = crc_in;
        cnt_nxt   = '0;
        state_nxt = CRC_SHIFT;
      end

      CRC_SHIFT: begin
        ser_valid = 1'b1;
        ser_phase = 1'b1;
        ser_bit   = creg[CRC_W-1];
        sl        = 1'b1;
        if (tx_ready) begin
          creg_nxt = {creg[CRC_W-2:0], 1'b0};
          cnt_nxt  = cnt + CW'(1);
          if (cnt == CW'(CRC_W - 1)) state_nxt = DONE;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
- Sequencing controller for the nibble-load / serial-shift / CRC-16 LFSR datapath.
- Accepts a frame of 4-bit nibbles over a valid/ready handshake and serializes each nibble MSB-first. The serial bit stream goes to the transmit side, and a qualified enable goes to the bit-serial CRC-16 LFSR.
- After the last nibble, it selects the LFSR result (sl=1), loads it, and shifts the 16 CRC bits out MSB-first behind the data.
- Owns LFSR clear, data/CRC select and frame-done signalling. The LFSR itself stays external.

Parameters:
- MAX_NIBBLES, 256, maximum nibbles per frame; counter width is clog2(MAX_NIBBLES)+1.
- CRC_W, 16, width of crc_in and CRC shift phase length.

Ports:
- Clk  in  1  system clock, rising edge.
- R  in  1  asynchronous, active-low reset.
- din  in  4  payload nibble.
- din_valid  in  1  din is valid.
- din_last  in  1  qualifies din as final nibble of frame.
- din_ready  out  1  controller accepts din this cycle.
- crc_in  in  CRC_W  current CRC register from LFSR.
- tx_ready  in  1  downstream consumes ser_bit this cycle.
- ser_bit  out  1  serial output bit.
- ser_valid  out  1  ser_bit valid.
- ser_phase  out  1  0=data bits, 1=CRC bits.
- lfsr_clr  out  1  one-cycle clear pulse to LFSR.
- lfsr_en  out  1  LFSR shift enable; LFSR input bit is ser_bit.
- sl  out  1  datapath select: 0=Din path, 1=CRC feedback path.
- busy  out  1  frame in progress (state != IDLE).
- done  out  1  one-cycle pulse, frame fully transmitted.
- ovf_err  out  1  sticky: frame truncated at MAX_NIBBLES.

Behaviour:
- Reset (R=0, async): state=IDLE, shift regs=0, counters=0. All outputs=0, including ovf_err.
- FSM states: IDLE, CLR, LOAD, SHIFT, CRC_CAP, CRC_SHIFT, DONE.
- IDLE: din_ready=0. On din_valid=1 → CLR. The nibble is not consumed.
- CLR: lfsr_clr=1 for exactly this cycle. nib_cnt=0, ovf_err cleared. → LOAD.
- LOAD: din_ready=1. On din_valid&din_ready:
  - dreg<=din, bit_cnt=0, nib_cnt++.
  - last_flag<=din_last | (nib_cnt+1==MAX_NIBBLES); ovf_err<=1 if the latter term alone made it last.
  - → SHIFT.
  - Without din_valid, stay in LOAD; there is no timeout.
- SHIFT: ser_valid=1, ser_phase=0, ser_bit=dreg[3], sl=0, lfsr_en=tx_ready.
  - On tx_ready: dreg shifts left, bit_cnt++.
  - After the 4th accepted bit: last_flag ? → CRC_CAP : → LOAD.
  - tx_ready=0: hold ser_bit, dreg and counters unchanged; lfsr_en=0.
- CRC_CAP: one cycle, sl=1, ser_valid=0, lfsr_en=0. creg<=crc_in; this lets the final LFSR update settle. → CRC_SHIFT.
- CRC_SHIFT: ser_valid=1, ser_phase=1, ser_bit=creg[CRC_W-1], sl=1, lfsr_en=0.
  - On tx_ready: shift creg left, count.
  - After CRC_W accepted bits → DONE. Same stall rule as SHIFT.
- DONE: done=1 for one cycle, busy=1, sl=0. → IDLE.
- busy=1 in every state except IDLE.
- Minimum frame length with tx_ready constantly 1 and din_valid held: 1 (IDLE) + 1 (CLR) + N×(1 LOAD + 4 SHIFT) + 1 + CRC_W + 1 cycles.
- din_last sampled only on accepted handshake; ignored in other states.
- Back-to-back: din_valid high in the cycle after DONE starts a new frame (IDLE→CLR). No frame starts during DONE.
- Reset asserted mid-frame: immediate return to IDLE, outputs 0. The partial frame is discarded; the next frame starts with a fresh CLR.
- ovf_err remains set after DONE until the next CLR.

Test Plan:
- One nibble 0xA, din_last=1, tx_ready=1:
  - lfsr_clr at cycle 1, din_ready at cycle 2.
  - ser_bit 1,0,1,0 with lfsr_en=1 at cycles 3-6.
  - sl=1 at cycle 7; crc_in=0xBEEF captured.
  - ser_bit stream 1011111011101111 with ser_phase=1 at cycles 8-23.
  - done at cycle 24.
- Three nibbles 0x1,0x2,0x3, last on 0x3:
  - data stream 0001 0010 0011.
  - exactly 12 lfsr_en pulses; din_ready exactly 3 cycles.
  - then 16 CRC bits, done once.
- Backpressure: tx_ready toggles 1,0 every cycle during the 0xA frame:
  - ser_bit stable while tx_ready=0; lfsr_en count still 4.
  - CRC bits identical to unstalled run; done delayed by 20 cycles.
- Overflow with MAX_NIBBLES=4, five nibbles, no din_last:
  - only 4 accepted, 16 data bits, then CRC phase; ovf_err=1 after 4th accept.
  - 5th nibble is still pending in IDLE and triggers a new frame; ovf_err clears at that frame's CLR.
- Reset mid-frame: R low during SHIFT bit 2 →
  - same-cycle (async) ser_valid=0, busy=0, din_ready=0, done=0.
  - after R high plus din_valid, lfsr_clr pulses before any data bit.
- Back-to-back frames: din_valid held high across DONE → IDLE lasts 1 cycle, new lfsr_clr next cycle, two done pulses total.
